adma_desc_fetch: RTL
====================

# adma_desc_fetch

Descriptor fetch unit for the ADMA engine. On request from the channel control FSM it reads one 32-byte descriptor (four 64-bit beats) over the Wishbone master port and presents the decoded fields to the control FSM with a valid/ready handshake. It sits directly upstream of the control FSM, between the NDAR/next-descriptor pointer and the descriptor execution logic. Bus retry and error responses are handled here, so the control FSM only sees a complete descriptor or an error.

## Interface
- RTY_MAX, 16: consecutive retries allowed on one beat before the fetch aborts with error.
- wb_clk_i  in  1  system clock, all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- fetch_start_i  in  1  one-cycle request to fetch a descriptor; honoured only in IDLE.
- fetch_adr_i  in  32  descriptor byte address, sampled with fetch_start_i.
- fetch_busy_o  out  1  high from the accepted start until the descriptor is consumed.
- desc_valid_o  out  1  descriptor (or error) available; held until desc_ready_i.
- desc_ready_i  in  1  consumer accepts the descriptor.
- desc_err_o  out  1  qualifies desc_valid_o: fetch failed.
- desc_next_o, desc_ctl_o, desc_dcfc_o, desc_src_o, desc_dst_o  out  32 each  next_desc, ctl_addr, dc_fc, src_desc, dst_desc.
- desc_op_o  out  8  dc_fc[7:0] opcode (1 NULL, 2 READ, 0x0D FILL, 0x16 COPY).
- desc_cont_o  out  1  dc_fc[14], the CONT flag.
- wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_we_o  out  1 each  Wishbone master controls; wbm_we_o is always 0.
- wbm_adr_o  out  32  beat address.
- wbm_sel_o  out  4  always 4'hF while cyc is high.
- wbm_dat_i, wbm_dat64_i  in  32 each  low and high halves of the 64-bit read data.
- wbm_ack_i, wbm_rty_i, wbm_err_i  in  1 each  slave responses.

## Operation
- States: IDLE, REQ, RTY, HOLD.
- IDLE: bus outputs 0. On fetch_start_i: if fetch_adr_i[2:0] != 0, go to HOLD with error. Otherwise latch the address, clear the beat counter (2 bits) and go to REQ.
- REQ: cyc=stb=1, adr = base + 8*beat, cab=1 for beats 0–2 and 0 for beat 3.
  - err_i: abort. Go to HOLD with error; all fields stay 0.
  - ack_i (without err_i): capture the beat, increment beat, clear the retry counter.
    - Beat 0: H→next, L→ctl.
    - Beat 1: H→dcfc, L discarded.
    - Beat 2: H→src.
    - Beat 3: H→dst, then go to HOLD.
  - rty_i (without ack_i or err_i): increment the retry counter. If the counter reaches RTY_MAX, go to HOLD with error. Otherwise go to RTY.
- RTY: cyc=1, stb=0 for exactly one cycle, then REQ with the same address.
- HOLD: cyc=stb=0, desc_valid_o=1, fields and desc_err_o stable. On desc_ready_i go to IDLE and clear desc_valid_o and desc_err_o. Fields keep their last values.
- Response priority when several arrive in the same cycle: err > ack > rty.
- fetch_start_i outside IDLE is ignored. This includes the cycle of the desc_ready_i handshake.
- Address wrap: base + 24 wraps modulo 2^32 with no special handling.

## Timing
- Reset values: every output is 0, including all fields, wbm_sel_o and wbm_adr_o. State returns to IDLE.
- Reset mid-burst: cyc drops at the next edge and no partial descriptor is signalled.
- Start accepted at edge N: cyc/stb/adr(base) are high after edge N.
- With zero-wait ack, acks are sampled at edges N+1 to N+4. desc_valid_o is high after N+4 and cyc is low after N+4.
- Each retry adds 2 cycles to the beat.
- Misaligned start: desc_valid_o=desc_err_o=1 after edge N; no bus cycle is issued.
- fetch_busy_o is high from after N until the edge where desc_ready_i is sampled in HOLD.
- desc_op_o and desc_cont_o are combinational slices of the registered dcfc.

## Test plan
- Basic NULL fetch: descriptor words H/L = {0x300/0x200, 0x1/0, 0x400/0, 0x500/0} at address 0, zero-wait ack, start. Expect:
  - next=0x300, ctl=0x200, op=0x01, cont=0, src=0x400, dst=0x500, err=0.
  - desc_valid_o rises 5 cycles after start.
  - Address sequence 0, 8, 0x10, 0x18; cab low only on the 0x18 beat.
- Chained CONT fetch at 0x80: dcfc=0x4001 → cont=1, op=0x01, next=0x100, ctl=0x2000. desc_ready_i held low for 10 cycles → valid and fields stable; the bus stays idle throughout.
- Retry: rty_i on beat 2 for 3 cycles, then ack. Expect:
  - Three one-cycle stb gaps, each with adr 0x10 reissued.
  - Correct src; total latency 11 cycles.
- Retry exhaustion: rty_i held permanently. Expect desc_err_o=1 with valid after 16 retries, cyc=0, fields 0.
- Bus error on beat 1 (err_i and ack_i together). Expect: error reported, no further beats issued, next stays 0.
- Corner cases:
  - Start with address 0x104 → immediate error, no cyc.
  - Start pulse during HOLD → ignored.
  - wb_rst_i asserted on beat 2 → all outputs 0 the next cycle; a fresh fetch afterwards completes correctly.

Source files
------------

// File: rtl/adma_desc_fetch.sv
// adma_desc_fetch: reads one 32-byte ADMA descriptor as four 64-bit Wishbone
// beats and hands the decoded fields to the channel control FSM.
module adma_desc_fetch #(
  parameter  int unsigned RTY_MAX = 16,
  localparam int unsigned AW      = 32,
  localparam int unsigned DW      = 32,
  localparam int unsigned SEL_W   = 4,
  localparam int unsigned OP_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             fetch_start_i,
  input  logic [AW-1:0]    fetch_adr_i,
  output logic             fetch_busy_o,
  output logic             desc_valid_o,
  input  logic             desc_ready_i,
  output logic             desc_err_o,
  output logic [DW-1:0]    desc_next_o,
  output logic [DW-1:0]    desc_ctl_o,
  output logic [DW-1:0]    desc_dcfc_o,
  output logic [DW-1:0]    desc_src_o,
  output logic [DW-1:0]    desc_dst_o,
  output logic [OP_W-1:0]  desc_op_o,
  output logic             desc_cont_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_cab_o,
  output logic             wbm_we_o,
  output logic [AW-1:0]    wbm_adr_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  input  logic [DW-1:0]    wbm_dat_i,
  input  logic [DW-1:0]    wbm_dat64_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_rty_i,
  input  logic             wbm_err_i
);

  localparam int unsigned BEAT_W   = 2;
  localparam int unsigned RTY_W    = $clog2(RTY_MAX + 1);
  localparam int unsigned CONT_BIT = 14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RTY  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [AW-1:0]       r_base,  w_base;
  logic [BEAT_W-1:0]   r_beat,  w_beat;
  logic [RTY_W-1:0]    r_rty,   w_rty;
  logic                r_err,   w_err;
  logic                r_valid, w_valid;
  logic                r_busy,  w_busy;
  logic [DW-1:0]       r_next,  w_next;
  logic [DW-1:0]       r_ctl,   w_ctl;
  logic [DW-1:0]       r_dcfc,  w_dcfc;
  logic [DW-1:0]       r_src,   w_src;
  logic [DW-1:0]       r_dst,   w_dst;
  logic                r_cyc,   w_cyc;
  logic                r_stb,   w_stb;
  logic                r_cab,   w_cab;
  logic [AW-1:0]       r_adr,   w_adr;
  logic [SEL_W-1:0]    r_sel,   w_sel;
  logic                w_clr;

  // State register and registered outputs; reset leaves every output at zero.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_beat  <= '0;
      r_rty   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_next  <= '0;
      r_ctl   <= '0;
      r_dcfc  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_cab   <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state;
      r_base  <= w_base;
      r_beat  <= w_beat;
      r_rty   <= w_rty;
      r_err   <= w_err;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_next  <= w_next;
      r_ctl   <= w_ctl;
      r_dcfc  <= w_dcfc;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_cyc   <= w_cyc;
      r_stb   <= w_stb;
      r_cab   <= w_cab;
      r_adr   <= w_adr;
      r_sel   <= w_sel;
    end
  end

  // Next-state, beat capture and next bus/handshake outputs.
  always_comb begin
    w_state = r_state;
    w_base  = r_base;
    w_beat  = r_beat;
    w_rty   = r_rty;
    w_err   = r_err;
    w_next  = r_next;
    w_ctl   = r_ctl;
    w_dcfc  = r_dcfc;
    w_src   = r_src;
    w_dst   = r_dst;
    w_clr   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (fetch_start_i) begin
          if (fetch_adr_i[2:0] != 3'd0) begin
            w_state = S_HOLD;
            w_err   = 1'b1;
            w_clr   = 1'b1;
          end else begin
            w_state = S_REQ;
            w_base  = fetch_adr_i;
            w_beat  = '0;
            w_rty   = '0;
            w_err   = 1'b0;
          end
        end
      end
      S_REQ: begin
        // Response priority: err over ack over rty.
        if (wbm_err_i) begin
          w_state = S_HOLD;
          w_err   = 1'b1;
          w_clr   = 1'b1;
        end else if (wbm_ack_i) begin
          w_rty  = '0;
          w_beat = r_beat + BEAT_W'(1);
          case (r_beat)
            2'd0: begin
              w_next = wbm_dat64_i;
              w_ctl  = wbm_dat_i;
            end
            2'd1: w_dcfc = wbm_dat64_i;
            2'd2: w_src  = wbm_dat64_i;
            default: begin
              w_dst   = wbm_dat64_i;
              w_state = S_HOLD;
            end
          endcase
        end else if (wbm_rty_i) begin
          w_rty = r_rty + RTY_W'(1);
          if (w_rty == RTY_W'(RTY_MAX)) begin
            w_state = S_HOLD;
            w_err   = 1'b1;
            w_clr   = 1'b1;
          end else begin
            w_state = S_RTY;
          end
        end
      end
      S_RTY: w_state = S_REQ;
      S_HOLD: begin
        if (desc_ready_i) begin
          w_state = S_IDLE;
          w_err   = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // A failed fetch never exposes partially captured words.
    if (w_clr) begin
      w_next = '0;
      w_ctl  = '0;
      w_dcfc = '0;
      w_src  = '0;
      w_dst  = '0;
    end

    w_cyc   = (w_state == S_REQ) || (w_state == S_RTY);
    w_stb   = (w_state == S_REQ);
    w_cab   = w_cyc && (w_beat != 2'd3);
    w_adr   = w_cyc ? (w_base + AW'({w_beat, 3'b000})) : '0;
    w_sel   = w_cyc ? '1 : '0;
    w_valid = (w_state == S_HOLD);
    w_busy  = (w_state != S_IDLE);
  end

  assign fetch_busy_o = r_busy;
  assign desc_valid_o = r_valid;
  assign desc_err_o   = r_err;
  assign desc_next_o  = r_next;
  assign desc_ctl_o   = r_ctl;
  assign desc_dcfc_o  = r_dcfc;
  assign desc_src_o   = r_src;
  assign desc_dst_o   = r_dst;
  assign desc_op_o    = r_dcfc[OP_W-1:0];
  assign desc_cont_o  = r_dcfc[CONT_BIT];
  assign wbm_cyc_o    = r_cyc;
  assign wbm_stb_o    = r_stb;
  assign wbm_cab_o    = r_cab;
  assign wbm_we_o     = 1'b0;
  assign wbm_adr_o    = r_adr;
  assign wbm_sel_o    = r_sel;

endmodule
